// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and default link rates.
// Used by both the transmitter and the receiver.
package uart_pkg;

  // Frame sequencing states, common to transmit and receive paths
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // Parity modes
  localparam int NENHUMA = 0;
  localparam int PAR     = 1;
  localparam int IMPAR   = 2;

  // Default system clock and serial rate
  localparam int FREQ_CLOCK_PADRAO = 50_000_000;
  localparam int BAUD_PADRAO       = 9600;

  // Parity bit for a byte: XOR of the data for even, its inverse for odd
  function automatic logic bit_paridade(input logic [7:0] dado, input int modo);
    return (^dado) ^ (modo == IMPAR);
  endfunction

endpackage

// File: rtl/transmitter_if.sv
// Byte handshake between the register interface (master) and the UART
// transmitter (slave). A byte moves on any edge with Valido and Pronto high.
interface transmitter_if;

  logic [7:0] Dado;
  logic       Valido;
  logic       Pronto;

  modport master (output Dado, output Valido, input Pronto);
  modport slave  (input Dado, input Valido, output Pronto);

endinterface

// File: rtl/baud_tick.sv
// Bit-period timer. Counts clock cycles and pulses tick_o for one cycle on
// the last cycle of each bit; the counter then wraps to zero. clear_i holds
// the count at zero so a new frame starts on a full bit period.
module baud_tick #(
  parameter int ClocksPorBit = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int W = (ClocksPorBit > 2) ? $clog2(ClocksPorBit) : 1;
  localparam logic [W-1:0] ULTIMO = W'(ClocksPorBit - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == ULTIMO);

  // Next count: restart on clear or at the bit boundary, otherwise advance
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// UART transmit stage. Takes one byte per Valido/Pronto handshake and sends
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OCIOSO   | idle, Tx high, Pronto high, waiting for Valido
// INICIO   | start bit (Tx low)
// DADOS    | data bits, shift[0] on the line, bit_cnt counts 0..7
// PARIDADE | parity bit (only when parity is enabled)
// PARADA   | stop bit(s), Tx high, stop_cnt counts the stop periods
//
// Tx and Pronto are registers updated in the same edge as the state, so the
// line never glitches and Valido has no combinational path to Tx.
module transmitter
  import uart_pkg::*;
#(
  parameter int FrequenciaClock = FREQ_CLOCK_PADRAO,
  parameter int BaudRate        = BAUD_PADRAO,
  parameter int ClocksPorBit    = FrequenciaClock / BaudRate,
  parameter int Paridade        = NENHUMA,
  parameter int BitsStop        = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  transmitter_if.slave       bus,
  output logic               Tx,
  output logic               Ocupado
);

  localparam bit   COM_PARIDADE = (Paridade != NENHUMA);
  localparam logic ULTIMO_STOP  = (BitsStop == 2);

  estado_t    estado_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       stop_cnt_q;
  logic       paridade_q;
  logic       tx_q;
  logic       pronto_q;

  logic       tick;
  logic       limpa_tick;

  // The bit timer sits at zero while idle, so the accept edge starts the
  // start bit with a full period in front of it.
  assign limpa_tick = (estado_q == OCIOSO);

  baud_tick #(
    .ClocksPorBit(ClocksPorBit)
  ) u_baud_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear_i(limpa_tick),
    .tick_o (tick)
  );

  assign Tx         = tx_q;
  assign bus.Pronto = pronto_q;
  assign Ocupado    = ~pronto_q;

  // Frame sequencer with registered Tx/Pronto; each bit change happens on tick
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q   <= OCIOSO;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      paridade_q <= 1'b0;
      tx_q       <= 1'b1;
      pronto_q   <= 1'b1;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (bus.Valido) begin
            shift_q    <= bus.Dado;
            paridade_q <= bit_paridade(bus.Dado, Paridade);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            pronto_q   <= 1'b0;
            estado_q   <= INICIO;
          end
        end

        INICIO: begin
          if (tick) begin
            tx_q     <= shift_q[0];
            estado_q <= DADOS;
          end
        end

        DADOS: begin
          if (tick) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (COM_PARIDADE) begin
                tx_q     <= paridade_q;
                estado_q <= PARIDADE;
              end else begin
                tx_q     <= 1'b1;
                estado_q <= PARADA;
              end
            end else begin
              // Next bit is shift[1]; load it as the register shifts right
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        PARIDADE: begin
          if (tick) begin
            tx_q     <= 1'b1;
            estado_q <= PARADA;
          end
        end

        PARADA: begin
          if (tick) begin
            if (stop_cnt_q == ULTIMO_STOP) begin
              stop_cnt_q <= 1'b0;
              pronto_q   <= 1'b1;
              estado_q   <= OCIOSO;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          tx_q     <= 1'b1;
          pronto_q <= 1'b1;
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

endmodule
